inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 clk  input  1  main clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous reset, active-high.
REQ-003 if_en  input  1  IF stage enable from controller; 0 freezes PC advance and IF/ID output register.
REQ-004 id_flush  input  1  squash: IF/ID output register loads a bubble this cycle.
REQ-005 redirect_en  input  1  taken jump/branch/JR from resolving stage.
REQ-006 redirect_addr  input  32  new PC; bits [1:0] ignored, forced 00.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  word-aligned fetch address.
REQ-009 imem_ack  input  1  single-cycle acknowledge; imem_data valid in the same cycle.
REQ-010 imem_data  input  32  fetched instruction.
REQ-011 if_valid  output  1  IF/ID register holds a real instruction.
REQ-012 inst_id  output  32  instruction to decode/controller.
REQ-013 pc_id  output  32  address of inst_id.
REQ-014 pc_next_id  output  32  pc_id + 4, used for link and branch base.

Function
REQ-015 States SHALL be IDLE, REQ, HOLD, DRAIN.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then go to REQ; imem_req=0 in IDLE.
REQ-017 In REQ and DRAIN imem_req SHALL be 1 and imem_addr SHALL stay stable until imem_ack.
REQ-018 Zero-wait memory (ack in the first request cycle) SHALL be supported; back-to-back fetches SHALL sustain one instruction per cycle.
REQ-019 REQ, ack, if_en=1, no redirect: IF/ID loads {imem_data, pc, pc+4}, if_valid=~id_flush, pc<=pc+4, stay in REQ.
REQ-020 REQ, ack, if_en=0, no redirect: data and pc captured in hold buffer, pc unchanged, go HOLD; imem_req=0 in HOLD.
REQ-021 HOLD, if_en=1: IF/ID loads from hold buffer (valid=~id_flush), pc<=pc+4, go REQ.
REQ-022 if_en=1 and no instruction delivered this cycle: IF/ID SHALL load a bubble (if_valid=0).
REQ-023 if_en=0: IF/ID register SHALL hold its contents, unless id_flush=1, which clears if_valid.
REQ-024 redirect_en has priority over all but rst: pc<=redirect_addr&~3 regardless of if_en.
REQ-025 Redirect in REQ without ack: go DRAIN; outstanding request completes at the old address and its data is discarded, then REQ at the new pc.
REQ-026 Redirect coincident with ack (REQ or DRAIN): data discarded, next state REQ at the new pc.
REQ-027 Redirect in HOLD: hold buffer discarded, go REQ.
REQ-028 Redirect in DRAIN without ack: pc updated again, remain DRAIN.
REQ-029 Discarded data SHALL never reach IF/ID; IF/ID loads a bubble in any cycle where if_en=1 and the only data is discarded.
REQ-030 PC arithmetic modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000.

Reset
REQ-031 On rst: pc=RESET_PC (32'h00000000), state IDLE, imem_req=0, imem_addr=RESET_PC, if_valid=0, inst_id=0, pc_id=0, pc_next_id=0, hold buffer cleared.
REQ-032 rst mid-request SHALL abandon the outstanding request; an ack arriving during the IDLE cycle after reset SHALL be ignored.

Structure
REQ-033 RESET_PC, the state encoding and the NOP word (32'h0) SHALL live in the shared define header alongside the existing PC_* and EXE_* constants.
REQ-034 Single module; no sub-module. The hold buffer is one 64-bit register {inst, pc}, not a FIFO.

Verification
REQ-035 Reset release with zero-wait memory -> imem_addr 0,4,8 on consecutive cycles; if_valid=1 from cycle 2; pc_id 0,4,8.
REQ-036 Ack at addr 0x10 with if_en=0 for 3 cycles -> state HOLD, imem_req=0, pc_id unchanged; when if_en=1, inst_id=data@0x10, next imem_addr=0x14.
REQ-037 Request at 0x20 with 2-cycle ack latency, redirect_en=1 to 0x100 in the first wait cycle -> imem_addr stays 0x20 until ack, data discarded (if_valid=0), next request at 0x100.
REQ-038 redirect_en=1 to 0x43 coincident with ack -> ack data dropped, next imem_addr=0x40.
REQ-039 id_flush=1 with ack and if_en=1 at 0x8 -> if_valid=0, next imem_addr=0xC.
REQ-040 pc=0xFFFFFFFC fetched -> pc_next_id=0x0, next imem_addr=0x0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: PC constants, state encoding, NOP word and hold-buffer layout.
package inst_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } hold_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: controller inputs, instruction-memory handshake and IF/ID outputs.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic            if_en;
    logic            id_flush;
    logic            redirect_en;
    logic [XLEN-1:0] redirect_addr;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_data;
    logic            if_valid;
    logic [XLEN-1:0] inst_id;
    logic [XLEN-1:0] pc_id;
    logic [XLEN-1:0] pc_next_id;

    modport master (
        input  if_en, id_flush, redirect_en, redirect_addr, imem_ack, imem_data,
        output imem_req, imem_addr, if_valid, inst_id, pc_id, pc_next_id
    );

    modport slave (
        output if_en, id_flush, redirect_en, redirect_addr, imem_ack, imem_data,
        input  imem_req, imem_addr, if_valid, inst_id, pc_id, pc_next_id
    );

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC sequencing, single-entry hold buffer, redirect draining, IF/ID register.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    inst_fetch_if.master bus
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    hold_t           hold;

    logic            deliver;
    logic [XLEN-1:0] deliver_inst;
    logic [XLEN-1:0] deliver_pc;
    logic [XLEN-1:0] redirect_pc;

    assign redirect_pc = word_align(bus.redirect_addr);

    // An instruction reaches IF/ID only when nothing redirects and decode can accept it.
    always_comb begin
        deliver      = 1'b0;
        deliver_inst = bus.imem_data;
        deliver_pc   = pc;
        if (!bus.redirect_en && bus.if_en) begin
            if (state == ST_REQ && bus.imem_ack) begin
                deliver = 1'b1;
            end else if (state == ST_HOLD) begin
                deliver      = 1'b1;
                deliver_inst = hold.inst;
                deliver_pc   = hold.pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            pc             <= RESET_PC;
            hold           <= '0;
            bus.imem_req   <= 1'b0;
            bus.imem_addr  <= RESET_PC;
            bus.if_valid   <= 1'b0;
            bus.inst_id    <= NOP_WORD;
            bus.pc_id      <= '0;
            bus.pc_next_id <= '0;
        end else begin
            if (deliver) begin
                bus.if_valid   <= !bus.id_flush;
                bus.inst_id    <= deliver_inst;
                bus.pc_id      <= deliver_pc;
                bus.pc_next_id <= deliver_pc + PC_STEP;
            end else if (bus.if_en) begin
                bus.if_valid <= 1'b0;
                bus.inst_id  <= NOP_WORD;
            end else if (bus.id_flush) begin
                bus.if_valid <= 1'b0;
            end

            // imem_addr only moves once the outstanding request has been acknowledged.
            case (state)
                ST_IDLE: begin
                    state        <= ST_REQ;
                    bus.imem_req <= 1'b1;
                    if (bus.redirect_en) begin
                        pc            <= redirect_pc;
                        bus.imem_addr <= redirect_pc;
                    end else begin
                        bus.imem_addr <= pc;
                    end
                end
                ST_REQ: begin
                    if (bus.redirect_en) begin
                        pc <= redirect_pc;
                        if (bus.imem_ack) begin
                            bus.imem_addr <= redirect_pc;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (bus.imem_ack) begin
                        if (bus.if_en) begin
                            pc            <= pc + PC_STEP;
                            bus.imem_addr <= pc + PC_STEP;
                        end else begin
                            hold         <= hold_t'{inst: bus.imem_data, pc: pc};
                            state        <= ST_HOLD;
                            bus.imem_req <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.redirect_en) begin
                        pc            <= redirect_pc;
                        bus.imem_addr <= redirect_pc;
                        hold          <= '0;
                        state         <= ST_REQ;
                        bus.imem_req  <= 1'b1;
                    end else if (bus.if_en) begin
                        pc            <= pc + PC_STEP;
                        bus.imem_addr <= pc + PC_STEP;
                        state         <= ST_REQ;
                        bus.imem_req  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (bus.redirect_en) begin
                        pc <= redirect_pc;
                    end
                    if (bus.imem_ack) begin
                        state         <= ST_REQ;
                        bus.imem_addr <= bus.redirect_en ? redirect_pc : pc;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    bus.imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: memory responder with programmable latency, fetch model, per-cycle compare.
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    inst_fetch_if bus ();

    inst_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int lat    = 0;
    bit stray  = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Memory: acks a request once it has been outstanding for lat cycles; stray forces an ack.
    initial begin
        logic [31:0] last_addr;
        bit          last_req;
        bit          last_ack;
        int          cnt;
        bus.imem_ack  = 1'b0;
        bus.imem_data = '0;
        last_addr = '0;
        last_req  = 1'b0;
        last_ack  = 1'b0;
        cnt       = 0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.imem_req === 1'b1 && last_req && !last_ack && bus.imem_addr === last_addr)
                cnt++;
            else
                cnt = 0;
            bus.imem_ack  = (bus.imem_req === 1'b1 && cnt >= lat) || stray;
            bus.imem_data = mem_word(bus.imem_addr);
            last_addr = bus.imem_addr;
            last_req  = (bus.imem_req === 1'b1);
            last_ack  = bus.imem_ack;
        end
    end

    // Fetch model: a program counter, one pending fetch address, a queue of parked words.
    bit          started = 1'b0;
    logic [31:0] m_pc, m_addr, m_inst, m_pcid, m_pcn;
    bit          m_req, m_idle, m_drain, m_valid;
    logic [63:0] parked[$];

    always @(posedge clk) begin
        bit          give;
        logic [31:0] gi, gp;
        give = 1'b0;
        gi   = '0;
        gp   = '0;
        if (rst) begin
            started = 1'b1;
            m_pc = '0; m_addr = '0; m_req = 1'b0; m_idle = 1'b1; m_drain = 1'b0;
            m_valid = 1'b0; m_inst = '0; m_pcid = '0; m_pcn = '0;
            parked.delete();
        end else if (started) begin
            if (bus.redirect_en) begin
                parked.delete();
                m_idle = 1'b0;
                m_pc   = bus.redirect_addr & ~32'h3;
                if (m_req && !bus.imem_ack) m_drain = 1'b1;
                else begin m_drain = 1'b0; m_addr = m_pc; end
                m_req = 1'b1;
            end else if (m_idle) begin
                m_idle = 1'b0; m_req = 1'b1; m_addr = m_pc;
            end else if (m_drain) begin
                if (bus.imem_ack) begin m_drain = 1'b0; m_addr = m_pc; end
            end else if (parked.size() != 0) begin
                if (bus.if_en) begin
                    give = 1'b1;
                    {gi, gp} = parked.pop_front();
                    m_pc = gp + 32'd4; m_addr = m_pc; m_req = 1'b1;
                end
            end else if (m_req && bus.imem_ack) begin
                if (bus.if_en) begin
                    give = 1'b1; gi = bus.imem_data; gp = m_pc;
                    m_pc = m_pc + 32'd4; m_addr = m_pc;
                end else begin
                    parked.push_back({bus.imem_data, m_pc});
                    m_req = 1'b0;
                end
            end
            if (give) begin
                m_valid = !bus.id_flush; m_inst = gi; m_pcid = gp; m_pcn = gp + 32'd4;
            end else if (bus.if_en || bus.id_flush) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_req",   32'(bus.imem_req), 32'(m_req));
            chk("model_addr",  bus.imem_addr,     m_addr);
            chk("model_valid", 32'(bus.if_valid), 32'(m_valid));
            if (m_valid) begin
                chk("model_inst",   bus.inst_id,    m_inst);
                chk("model_pc_id",  bus.pc_id,      m_pcid);
                chk("model_pc_nxt", bus.pc_next_id, m_pcn);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic redir(input logic [31:0] a);
        bus.redirect_en   = 1'b1;
        bus.redirect_addr = a;
        nxt();
        bus.redirect_en = 1'b0;
    endtask

    task automatic wait_addr(input logic [31:0] a);
        int n = 0;
        while (!(bus.imem_req === 1'b1 && bus.imem_addr === a) && n < 20) begin
            nxt();
            n++;
        end
        chk("reach_addr", bus.imem_addr, a);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] keep_pc;
        logic [47:0] pat;
        rst = 1'b1;
        bus.if_en = 1'b1; bus.id_flush = 1'b0;
        bus.redirect_en = 1'b0; bus.redirect_addr = '0;
        repeat (3) @(posedge clk);
        smp();
        chk("rst_req",   32'(bus.imem_req), 32'd0);
        chk("rst_addr",  bus.imem_addr,     32'h0);
        chk("rst_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_inst",  bus.inst_id,       32'h0);
        chk("rst_pc_id", bus.pc_id,         32'h0);
        chk("rst_pc_nx", bus.pc_next_id,    32'h0);

        // Release with a stray ack in the idle cycle, then zero-wait streaming.
        nxt(); rst = 1'b0; stray = 1'b1;
        smp(); chk("idle_req", 32'(bus.imem_req), 32'd0);
        nxt(); stray = 1'b0;
        smp(); chk("c1_addr", bus.imem_addr, 32'h0); chk("c1_valid", 32'(bus.if_valid), 32'd0);
        nxt(); smp();
        chk("c2_addr", bus.imem_addr, 32'h4); chk("c2_valid", 32'(bus.if_valid), 32'd1);
        chk("c2_pc_id", bus.pc_id, 32'h0); chk("c2_inst", bus.inst_id, mem_word(32'h0));
        nxt(); smp();
        chk("c3_addr", bus.imem_addr, 32'h8); chk("c3_pc_id", bus.pc_id, 32'h4);

        // Stall at 0x10 for three cycles.
        nxt(); redir(32'h10); wait_addr(32'h10);
        keep_pc = bus.pc_id; bus.if_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            nxt(); smp();
            chk("hold_req", 32'(bus.imem_req), 32'd0);
            chk("hold_pc_id", bus.pc_id, keep_pc);
        end
        nxt(); bus.if_en = 1'b1;
        smp(); chk("hold_req3", 32'(bus.imem_req), 32'd0);
        nxt(); smp();
        chk("hold_inst", bus.inst_id, mem_word(32'h10));
        chk("hold_pc", bus.pc_id, 32'h10);
        chk("hold_next_addr", bus.imem_addr, 32'h14);

        // Redirect while 0x20 is outstanding with two wait cycles.
        nxt(); redir(32'h20); wait_addr(32'h20);
        lat = 2; bus.redirect_en = 1'b1; bus.redirect_addr = 32'h100;
        nxt(); bus.redirect_en = 1'b0;
        smp(); chk("drain_addr1", bus.imem_addr, 32'h20); chk("drain_req1", 32'(bus.imem_req), 32'd1);
        nxt(); smp(); chk("drain_addr2", bus.imem_addr, 32'h20);
        nxt(); lat = 0;
        smp(); chk("drain_new", bus.imem_addr, 32'h100); chk("drain_valid", 32'(bus.if_valid), 32'd0);
        nxt(); smp(); chk("drain_pc_id", bus.pc_id, 32'h100);

        // Redirect coincident with ack, unaligned target.
        nxt(); redir(32'h43);
        smp(); chk("coin_addr", bus.imem_addr, 32'h40); chk("coin_valid", 32'(bus.if_valid), 32'd0);
        nxt(); smp(); chk("coin_pc_id", bus.pc_id, 32'h40);

        // Flush coincident with delivery at 0x8.
        nxt(); redir(32'h8); bus.id_flush = 1'b1;
        nxt(); bus.id_flush = 1'b0;
        smp(); chk("flush_valid", 32'(bus.if_valid), 32'd0); chk("flush_addr", bus.imem_addr, 32'hC);
        nxt(); smp(); chk("flush_pc_id", bus.pc_id, 32'hC);

        // Address wrap.
        nxt(); redir(32'hFFFF_FFFC);
        nxt(); smp();
        chk("wrap_pc_id", bus.pc_id, 32'hFFFF_FFFC);
        chk("wrap_pc_nx", bus.pc_next_id, 32'h0);
        chk("wrap_addr", bus.imem_addr, 32'h0);

        // Redirect while parked in the hold buffer.
        nxt(); bus.if_en = 1'b0;
        nxt(); smp(); chk("hredir_req0", 32'(bus.imem_req), 32'd0);
        nxt(); redir(32'h200); bus.if_en = 1'b1;
        smp(); chk("hredir_addr", bus.imem_addr, 32'h200);
        nxt(); smp(); chk("hredir_pc_id", bus.pc_id, 32'h200);

        // Second redirect while draining.
        nxt(); a = bus.imem_addr; lat = 3;
        bus.redirect_en = 1'b1; bus.redirect_addr = 32'h300;
        nxt(); bus.redirect_addr = 32'h400;
        nxt(); bus.redirect_en = 1'b0;
        smp(); chk("redrain_addr", bus.imem_addr, a);
        nxt(); smp(); chk("redrain_addr2", bus.imem_addr, a);
        nxt(); lat = 0;
        smp(); chk("redrain_new", bus.imem_addr, 32'h400);
        nxt(); smp(); chk("redrain_pc_id", bus.pc_id, 32'h400);

        // Reset in the middle of a slow request.
        nxt(); lat = 3;
        nxt(); rst = 1'b1;
        nxt(); rst = 1'b0; stray = 1'b1;
        smp(); chk("mrst_req", 32'(bus.imem_req), 32'd0); chk("mrst_valid", 32'(bus.if_valid), 32'd0);
        nxt(); stray = 1'b0; lat = 0;
        smp(); chk("mrst_addr", bus.imem_addr, 32'h0);
        nxt(); smp(); chk("mrst_pc_id", bus.pc_id, 32'h0);

        // Flush while stalled clears the IF/ID entry.
        nxt(); bus.if_en = 1'b0; bus.id_flush = 1'b1;
        nxt(); bus.id_flush = 1'b0;
        smp(); chk("stall_flush", 32'(bus.if_valid), 32'd0);
        nxt(); bus.if_en = 1'b1;

        // Mixed enable/latency/redirect/flush pattern, checked by the model.
        pat = 48'hF3A5_96C3_7E1D;
        for (int i = 0; i < 48; i++) begin
            nxt();
            bus.if_en       = pat[i];
            bus.id_flush    = (i % 7 == 3);
            lat             = i % 3;
            bus.redirect_en = (i % 11 == 5);
            bus.redirect_addr = 32'h1000 + 32'(i * 8) + 32'd2;
        end
        nxt(); bus.redirect_en = 1'b0; bus.id_flush = 1'b0; bus.if_en = 1'b1; lat = 0;
        repeat (4) nxt();
        smp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
